// File: rtl/row_fetch_ctrl.sv
// Row fetch controller: pulls one display row from memory in fixed-length bursts
// and writes it into the half of a ping-pong row buffer currently being filled.
module row_fetch_ctrl #(
    parameter int unsigned WORDS_PER_ROW = 80,
    parameter int unsigned BURST_LEN     = 8,
    parameter int unsigned NUM_ROWS      = 480,
    parameter logic [23:0] BASE_ADDR     = 24'h000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         line_req,
    input  logic [8:0]   line_num,
    output logic         rd_req,
    output logic [23:0]  rd_addr,
    input  logic         rd_gnt,
    input  logic         rd_valid,
    input  logic [127:0] rd_data,
    output logic         buf_wr_en,
    output logic [6:0]   buf_wr_address,
    output logic [127:0] buf_wr_data,
    output logic         buf_sel,
    output logic         busy,
    output logic         line_done,
    output logic [1:0]   err
);

    localparam int unsigned NUM_BURSTS = WORDS_PER_ROW / BURST_LEN;
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int BIDX_W = $clog2(NUM_BURSTS) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RECV = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [6:0]        LAST_WORD = 7'(WORDS_PER_ROW - 1);

    logic [1:0]         state_q, state_d;
    logic [8:0]         line_q;
    logic [BIDX_W-1:0]  burst_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [6:0]         word_q;
    logic               wr_en_q;
    logic [6:0]         wr_addr_q;
    logic [127:0]       wr_data_q;
    logic               sel_q;
    logic [1:0]         err_q;

    logic               in_range;
    logic               accept;
    logic               bad_line;
    logic               overrun;
    logic               granted;
    logic               beat;
    logic               last_beat;
    logic               last_word;
    logic [23:0]        row_base;
    logic [23:0]        burst_off;
    logic [23:0]        req_addr;

    // Decode the events that drive every register update below
    always_comb begin
        in_range  = (32'(line_num) < NUM_ROWS);
        accept    = (state_q == IDLE) && line_req && in_range;
        bad_line  = (state_q == IDLE) && line_req && !in_range;
        // A request arriving mid-fetch (DONE included) is dropped and flagged
        overrun   = line_req && (state_q != IDLE);
        granted   = (state_q == REQ) && rd_gnt;
        // Beats are only counted while a burst is outstanding
        beat      = (state_q == RECV) && rd_valid;
        last_beat = beat && (beat_q == LAST_BEAT);
        last_word = beat && (word_q == LAST_WORD);
    end

    // Burst address: row base plus burst offset, wrapping at 24 bits
    always_comb begin
        row_base  = 24'(line_q) * 24'(WORDS_PER_ROW);
        burst_off = 24'(burst_q) * 24'(BURST_LEN);
        req_addr  = BASE_ADDR + row_base + burst_off;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (rd_gnt) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (last_beat) begin
                    state_d = last_word ? DONE : REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Row, burst, beat and word counters
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            word_q  <= '0;
        end else begin
            if (accept) begin
                line_q  <= line_num;
                burst_q <= '0;
                word_q  <= '0;
            end
            if (granted) begin
                beat_q <= '0;
            end
            if (beat) begin
                beat_q <= beat_q + BEAT_W'(1);
                word_q <= word_q + 7'd1;
            end
            if (last_beat && !last_word) begin
                burst_q <= burst_q + BIDX_W'(1);
            end
        end
    end

    // Registered buffer write port: one cycle behind the accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= beat;
            if (beat) begin
                wr_addr_q <= word_q;
                wr_data_q <= rd_data;
            end
        end
    end

    // Ping-pong select flips once the row is complete; error flags are sticky
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= 1'b0;
            err_q <= '0;
        end else begin
            if (state_q == DONE) begin
                sel_q <= ~sel_q;
            end
            err_q <= err_q | {bad_line, overrun};
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        rd_req         = (state_q == REQ);
        rd_addr        = (state_q == REQ) ? req_addr : 24'd0;
        busy           = (state_q != IDLE);
        line_done      = (state_q == DONE);
        buf_wr_en      = wr_en_q;
        buf_wr_address = wr_addr_q;
        buf_wr_data    = wr_data_q;
        buf_sel        = sel_q;
        err            = err_q;
    end

endmodule

// File: tb/tb_row_fetch_ctrl.sv
// Scoreboard bench for row_fetch_ctrl: a memory responder serves bursts, a
// reference model queues the expected requests and buffer writes, a monitor checks.
module tb_row_fetch_ctrl;

    localparam int WPR = 80;
    localparam int BL  = 8;
    localparam int NR  = 480;
    localparam int NB  = WPR / BL;

    typedef struct packed {
        logic [6:0]   addr;
        logic [127:0] data;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         line_req;
    logic [8:0]   line_num;
    logic         rd_req;
    logic [23:0]  rd_addr;
    logic         rd_gnt;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic         buf_wr_en;
    logic [6:0]   buf_wr_address;
    logic [127:0] buf_wr_data;
    logic         buf_sel;
    logic         busy;
    logic         line_done;
    logic [1:0]   err;

    logic         resp_valid;
    logic [127:0] resp_data;
    logic         stray_valid;

    assign rd_valid = resp_valid | stray_valid;
    assign rd_data  = stray_valid ? 128'hDEAD_BEEF_0BAD_F00D_DEAD_BEEF_0BAD_F00D : resp_data;

    row_fetch_ctrl #(
        .WORDS_PER_ROW (WPR),
        .BURST_LEN     (BL),
        .NUM_ROWS      (NR),
        .BASE_ADDR     (24'h000000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .line_req       (line_req),
        .line_num       (line_num),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_gnt         (rd_gnt),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .buf_wr_en      (buf_wr_en),
        .buf_wr_address (buf_wr_address),
        .buf_wr_data    (buf_wr_data),
        .buf_sel        (buf_sel),
        .busy           (busy),
        .line_done      (line_done),
        .err            (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    wr_t         exp_wr[$];
    logic [23:0] exp_addr[$];
    logic [1:0]  exp_err = 2'b00;
    logic        exp_sel = 1'b0;
    logic        sel_pend = 1'b0;
    int          exp_done = 0;
    int          n_done = 0;
    int          n_wr = 0;
    bit          model_busy = 0;
    int          resp_total = 0;
    int          row_target = 0;
    bit          resp_active = 0;
    int          gnt_delay = 0;
    int          gap_max = 0;
    logic [31:0] salt = 32'h0;

    // Memory contents as a pure function of word address
    function automatic logic [127:0] beat_data(input logic [23:0] a);
        logic [31:0] h;
        h = (32'(a) * 32'h9E3779B1) ^ salt;
        return {8'hA5, a, h, ~{8'h00, a}, 8'h3C, a ^ 24'hC3C3C3};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Reference model: a valid request in an idle controller yields NB bursts and WPR writes
    task automatic drive_req(input logic [8:0] l);
        line_req = 1'b1;
        line_num = l;
        if (model_busy) begin
            exp_err[0] = 1'b1;
        end else if (int'(l) >= NR) begin
            exp_err[1] = 1'b1;
        end else begin
            model_busy = 1;
            exp_done++;
            row_target = resp_total + WPR;
            for (int b = 0; b < NB; b++) exp_addr.push_back(24'(int'(l) * WPR + b * BL));
            for (int w = 0; w < WPR; w++)
                exp_wr.push_back('{addr: 7'(w), data: beat_data(24'(int'(l) * WPR + w))});
        end
    endtask

    task automatic end_req();
        @(negedge clk);
        line_req = 1'b0;
        line_num = 9'($urandom);
    endtask

    // Returns just after the negedge on which the row's final beat is driven
    task automatic wait_row_end();
        int t = 0;
        while (resp_total < row_target && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 3000) fail_now("row_complete");
    endtask

    // Final beat -> DONE cycle -> first IDLE cycle
    task automatic finish_row();
        wait_row_end();
        @(negedge clk);
        @(negedge clk);
        model_busy = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_req"}, rd_req, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_wr_en"}, buf_wr_en, 0);
        chk({tag, "_wr_addr"}, buf_wr_address, 0);
        chk({tag, "_wr_data"}, buf_wr_data, 0);
        chk({tag, "_buf_sel"}, buf_sel, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_line_done"}, line_done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Memory responder: grant after gnt_delay, then BL beats with random gaps
    initial begin
        rd_gnt     = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        forever begin
            @(negedge clk);
            if (rd_req && !rst) begin
                logic [23:0] a;
                resp_active = 1;
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rd_req actual=%0h required=none", rd_addr);
                    a = rd_addr;
                end else begin
                    a = exp_addr.pop_front();
                end
                chk("rd_addr", rd_addr, a);
                for (int i = 0; i < gnt_delay; i++) begin
                    @(negedge clk);
                    chk("rd_req_hold", rd_req, 1);
                    chk("rd_addr_hold", rd_addr, a);
                end
                rd_gnt = 1'b1;
                @(negedge clk);
                rd_gnt = 1'b0;
                for (int b = 0; b < BL; b++) begin
                    int g;
                    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
                    repeat (g) @(negedge clk);
                    chk("one_outstanding", rd_req, 0);
                    resp_valid = 1'b1;
                    resp_data  = beat_data(a + 24'(b));
                    resp_total++;
                    @(negedge clk);
                    resp_valid = 1'b0;
                end
                resp_active = 0;
            end
        end
    end

    // Monitor: pop and compare every buffer write, check line_done and buf_sel
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                logic last;
                wr_t  e;
                last = 1'b0;
                if (sel_pend) begin
                    exp_sel  = ~exp_sel;
                    sel_pend = 1'b0;
                end
                chk("buf_sel", buf_sel, exp_sel);
                if (buf_wr_en) begin
                    n_wr++;
                    if (exp_wr.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_write actual=%0h required=none", buf_wr_address);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", buf_wr_address, e.addr);
                        chk("wr_data", buf_wr_data, e.data);
                        last = (e.addr == 7'(WPR - 1));
                    end
                end
                chk("line_done", line_done, last);
                if (line_done) n_done++;
                if (last) sel_pend = 1'b1;
            end
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog actual=timeout required=finish");
        n_errors++;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] l;
        int         t;
        int         wr_base;
        rst         = 1'b1;
        line_req    = 1'b0;
        line_num    = '0;
        stray_valid = 1'b0;
        salt        = $urandom;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Row 0 then row 479 back-to-back, ideal memory
        @(negedge clk);
        drive_req(9'd0);
        end_req();
        finish_row();
        chk("buf_sel_after_row0", buf_sel, 1);
        drive_req(9'd479);
        end_req();
        finish_row();
        chk("buf_sel_after_row479", buf_sel, 0);

        // Out-of-range row
        drive_req(9'd480);
        end_req();
        for (int i = 0; i < 4; i++) begin
            chk("busy_bad_line", busy, 0);
            chk("rd_req_bad_line", rd_req, 0);
            @(negedge clk);
        end
        chk("err_bad_line", err, exp_err);

        // Stray beat in IDLE, slow grant, gappy beats, overrun during burst 3
        gnt_delay = 5;
        gap_max   = 3;
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        repeat (2) @(negedge clk);
        l = 9'($urandom_range(NR - 1, 0));
        drive_req(l);
        end_req();
        t = 0;
        while (resp_total < row_target - WPR + 27 && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 3000) fail_now("burst3_reached");
        drive_req(9'($urandom_range(NR - 1, 0)));
        end_req();
        finish_row();
        chk("err_overrun", err, exp_err);

        // Reset after 20 words written
        l = 9'($urandom_range(NR - 1, 0));
        wr_base = n_wr;
        drive_req(l);
        end_req();
        t = 0;
        while (n_wr < wr_base + 20 && t < 3000) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (t >= 3000) fail_now("twenty_words");
        @(negedge clk);
        rst = 1'b1;
        exp_wr.delete();
        exp_addr.delete();
        exp_done--;
        model_busy = 0;
        exp_err    = 2'b00;
        exp_sel    = 1'b0;
        sel_pend   = 1'b0;
        @(posedge clk);
        #2;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        t = 0;
        while (resp_active && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 200) fail_now("responder_idle");

        // Fresh fetch, overrun in DONE, then accept in first IDLE cycle
        @(negedge clk);
        drive_req(9'($urandom_range(NR - 1, 0)));
        end_req();
        wait_row_end();
        @(negedge clk);
        drive_req(9'($urandom_range(NR - 1, 0)));
        @(negedge clk);
        chk("buf_sel_after_reset_row", buf_sel, 1);
        model_busy = 0;
        drive_req(9'($urandom_range(NR - 1, 0)));
        end_req();
        finish_row();
        chk("err_done_overrun", err, exp_err);

        // Random rows, random memory timing, back-to-back
        for (int k = 0; k < 4; k++) begin
            gnt_delay = int'($urandom_range(3, 0));
            gap_max   = int'($urandom_range(2, 0));
            drive_req(9'($urandom_range(NR - 1, 0)));
            end_req();
            finish_row();
        end

        repeat (5) @(negedge clk);
        chk("err_final", err, exp_err);
        chk("busy_final", busy, 0);
        chk("writes_left", 32'(exp_wr.size()), 0);
        chk("addrs_left", 32'(exp_addr.size()), 0);
        chk("line_done_count", 32'(n_done), 32'(exp_done));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/row_fetch_ctrl.md
ROW_FETCH_CTRL -- requirements
Module: row_fetch_ctrl

Interface
REQ-001 SHALL have parameter WORDS_PER_ROW, default 80, meaning 128-bit words per display row (640 x 16-bit pixels).
REQ-002 SHALL have parameter BURST_LEN, default 8, meaning 128-bit beats per memory read request; WORDS_PER_ROW SHALL be a multiple of BURST_LEN.
REQ-003 SHALL have parameter NUM_ROWS, default 480, meaning valid line numbers 0..NUM_ROWS-1.
REQ-004 SHALL have parameter BASE_ADDR, default 24'h000000, meaning word address of row 0.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 line_req  input  1  single-cycle pulse requesting a row fetch.
REQ-008 line_num  input  9  row to fetch, sampled when line_req=1.
REQ-009 rd_req  output  1  memory read request.
REQ-010 rd_addr  output  24  word address of the requested burst.
REQ-011 rd_gnt  input  1  memory accepts the request when rd_req=1 and rd_gnt=1 in the same cycle.
REQ-012 rd_valid  input  1  one read beat present on rd_data.
REQ-013 rd_data  input  128  read beat data.
REQ-014 buf_wr_en  output  1  row buffer write strobe.
REQ-015 buf_wr_address  output  7  row buffer word address.
REQ-016 buf_wr_data  output  128  row buffer write data.
REQ-017 buf_sel  output  1  ping-pong buffer being filled; display reads ~buf_sel.
REQ-018 busy  output  1  fetch in progress.
REQ-019 line_done  output  1  single-cycle pulse: row completely written.
REQ-020 err  output  2  sticky flags: bit0 overrun, bit1 line_num out of range.

Function
REQ-021 SHALL implement FSM states IDLE, REQ, RECV, DONE; busy=1 in every state except IDLE.
REQ-022 IDLE: line_req=1 with line_num<NUM_ROWS -> latch line_num, clear word/burst counters, go to REQ next edge.
REQ-023 IDLE: line_req=1 with line_num>=NUM_ROWS -> set err[1], stay in IDLE, issue no request.
REQ-024 line_req=1 while not in IDLE -> set err[0], ignore request, current fetch unaffected.
REQ-025 REQ: rd_req=1, rd_addr=(BASE_ADDR + line*WORDS_PER_ROW + burst_idx*BURST_LEN) mod 2^24, held stable until grant; on rd_gnt=1 go to RECV and reset beat counter.
REQ-026 rd_req SHALL be 0 in all states except REQ; never more than one burst outstanding.
REQ-027 RECV: each rd_valid=1 beat SHALL produce, next cycle, buf_wr_en=1, buf_wr_data=that beat, buf_wr_address=word counter; word counter then increments (one-cycle registered latency).
REQ-028 rd_valid in IDLE, REQ or DONE SHALL be ignored (no write, no counter change).
REQ-029 RECV: after BURST_LEN beats, go to REQ with burst_idx+1, or to DONE if WORDS_PER_ROW words received.
REQ-030 Same cycle as final beat's rd_valid, rd_valid in a following cycle is not counted.
REQ-031 DONE: lasts one cycle, coincides with last buf_wr_en; line_done=1 for that cycle; buf_sel toggles at the following edge; return to IDLE.
REQ-032 line_req in the DONE cycle SHALL be treated per REQ-024 (overrun).
REQ-033 buf_wr_address SHALL span 0..WORDS_PER_ROW-1 per row, no wrap within a row.
REQ-034 err bits SHALL clear only on rst.
REQ-035 Back-to-back: line_req in the first IDLE cycle after DONE SHALL be accepted normally.

Reset
REQ-036 rst=1 SHALL force next edge: state IDLE, rd_req=0, rd_addr=0, buf_wr_en=0, buf_wr_address=0, buf_wr_data=0, buf_sel=0, busy=0, line_done=0, err=0, counters 0.
REQ-037 rst mid-fetch SHALL abandon the fetch; beats arriving after reset deasserts SHALL be ignored per REQ-028.

Verification
REQ-038 line_req, line_num=0, rd_gnt always 1, beats back-to-back -> 10 requests addr 0,8,..,72; 80 writes addr 0..79 in order; one line_done; buf_sel 0->1.
REQ-039 line_num=479 -> first rd_addr=38320 (479*80), last 38392; line_done; buf_sel toggles.
REQ-040 line_num=480 -> err=2'b10, no rd_req, busy stays 0.
REQ-041 line_req during RECV of burst 3 -> err[0]=1, fetch completes all 80 writes unchanged.
REQ-042 rd_gnt delayed 5 cycles, gaps between beats, stray rd_valid in IDLE -> rd_addr stable while waiting; exactly 80 writes; stray beat produces no write.
REQ-043 rst asserted after 20 words -> all outputs at reset values next edge; new line_req afterwards fetches fully, buf_sel 0->1.
